// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Holds the channel FSM state encoding and default parameter values.
package btn_pkg;

   typedef logic [1:0] btn_state_t;

   localparam btn_state_t IDLE       = 2'd0;
   localparam btn_state_t PRESS_WAIT = 2'd1;
   localparam btn_state_t HELD       = 2'd2;
   localparam btn_state_t REL_WAIT   = 2'd3;

   localparam int DEF_N_BTN            = 5;
   localparam int DEF_DEBOUNCE_CYC     = 250000;
   localparam int DEF_REPEAT_DELAY_CYC = 50000000;
   localparam int DEF_REPEAT_RATE_CYC  = 10000000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between raw pad inputs and the calculator core.
// btn_raw in, btn_level/btn_press/any_press out (slave = conditioner).
interface btn_conditioner_if
   import btn_pkg::*;
#(
   parameter int N_BTN = DEF_N_BTN
);

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic             any_press;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  any_press
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output any_press
   );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional repeat.
// Ports: clk, rst, raw_i -> level_o, press_o, press_d_o (next press). Macro: BTN_REPEAT_EN.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
   parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic press_d_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;

`ifdef BTN_REPEAT_EN
   localparam int REP_W = $clog2(max_int(REPEAT_DELAY_CYC, REPEAT_RATE_CYC) + 1);
   localparam logic [REP_W-1:0] REP_DLY_LAST  = REP_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [REP_W-1:0] REP_RATE_LAST = REP_W'(REPEAT_RATE_CYC - 1);

   // rep_ph: 0 = waiting out the initial delay, 1 = periodic repeat phase
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_ph_q, rep_ph_d;
`else
   logic unused_rep;
   assign unused_rep = ^{REPEAT_DELAY_CYC, REPEAT_RATE_CYC};
`endif

   always_comb begin
      s1_d    = raw_i;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
`ifdef BTN_REPEAT_EN
      rep_cnt_d = rep_cnt_q;
      rep_ph_d  = rep_ph_q;
`endif
      case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               level_d = 1'b1;
               press_d = 1'b1;
`ifdef BTN_REPEAT_EN
               rep_cnt_d = '0;
               rep_ph_d  = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!s2_q) begin
               state_d = REL_WAIT;
               cnt_d   = '0;
            end
`ifdef BTN_REPEAT_EN
            // Repeat phase reloads to zero each period so the count never wraps past its limit.
            else if (!rep_ph_q) begin
               if (rep_cnt_q == REP_DLY_LAST) begin
                  press_d   = 1'b1;
                  rep_ph_d  = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end else begin
               if (rep_cnt_q == REP_RATE_LAST) begin
                  press_d   = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
`endif
         end
         REL_WAIT: begin
            // A bounce back to pressed resumes HELD with the repeat count intact.
            if (s2_q) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

`ifdef BTN_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_q <= '0;
         rep_ph_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_ph_q  <= rep_ph_d;
      end
   end
`endif

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign press_d_o = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: debounced levels and press pulses.
// Ports: clk, rst, bus (btn_conditioner_if.slave). Optional macro: BTN_REPEAT_EN.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN            = DEF_N_BTN,
   parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
   parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
   input  logic               clk,
   input  logic               rst,
   btn_conditioner_if.slave   bus
);

   logic [N_BTN-1:0] level_w;
   logic [N_BTN-1:0] press_w;
   logic [N_BTN-1:0] press_nxt;
   logic             any_press_q, any_press_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYC     (DEBOUNCE_CYC),
         .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
         .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (bus.btn_raw[i]),
         .level_o   (level_w[i]),
         .press_o   (press_w[i]),
         .press_d_o (press_nxt[i])
      );
   end

   // Reduce the channels' next-press values so any_press lands with btn_press.
   always_comb begin
      any_press_d = |press_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= any_press_d;
      end
   end

   assign bus.btn_level = level_w;
   assign bus.btn_press = press_w;
   assign bus.any_press = any_press_q;

endmodule
